dla_layer_launcher: RTL and testbench

Host-side command sequencer that drives the DLA top-level control-register write port. It buffers layer descriptors, programs the four control registers for each layer, starts the accelerator, and waits for `dla_done`. It then releases the start bit, waits for the accelerator to return to idle, and reports per-layer completion with a cycle count. It sits between the host/CPU bus and the DLA top, acting as the initiator for that top's control-register responder.

---
 rtl/dla_launcher_pkg.sv | 34 +++
 rtl/desc_fifo.sv | 54 +++++
 rtl/dla_layer_launcher.sv | 190 +++++++++++++++++++
 tb/tb_dla_layer_launcher.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dla_launcher_pkg.sv
// Shared types for the DLA layer launcher: FSM states, control-register selects
// and the buffered layer descriptor.
package dla_launcher_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_MAP,
    ST_WR_SH1,
    ST_WR_SH2,
    ST_WR_START,
    ST_WAIT_DONE,
    ST_WR_CLEAR,
    ST_WAIT_IDLE
  } state_e;

  localparam logic [1:0] WSEL_MAPPING = 2'd0;
  localparam logic [1:0] WSEL_SHAPE1  = 2'd1;
  localparam logic [1:0] WSEL_SHAPE2  = 2'd2;
  localparam logic [1:0] WSEL_OPCFG   = 2'd3;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] mapping;
    logic [31:0] shape1;
    logic [31:0] shape2;
    logic [31:0] op;
  } desc_t;

  // Bit 0 of the op-config register is the accelerator start bit.
  function automatic logic [31:0] op_with_start(input logic [31:0] op, input logic start);
    return {op[31:1], start};
  endfunction

endpackage

// File: rtl/desc_fifo.sv
// Fall-through descriptor FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguishable when the index bits match.
module desc_fifo
  import dla_launcher_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  desc_t wr_data,
  output desc_t rd_data,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  desc_t          mem_q [DEPTH];
  logic  [AW:0]   wr_ptr_q, wr_ptr_d;
  logic  [AW:0]   rd_ptr_q, rd_ptr_d;
  logic           do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/dla_layer_launcher.sv
// Host-side sequencer: buffers layer descriptors, programs the DLA control
// registers, starts each layer, waits for done and reports completion.
module dla_layer_launcher
  import dla_launcher_pkg::*;
#(
  parameter int          DESC_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [7:0]  desc_id,
  input  logic [31:0] desc_mapping,
  input  logic [31:0] desc_shape1,
  input  logic [31:0] desc_shape2,
  input  logic [31:0] desc_op,
  output logic        ctrl_reg_w_en,
  output logic [1:0]  ctrl_reg_wsel,
  output logic [31:0] ctrl_reg_wdata,
  input  logic        dla_done,
  output logic        cpl_valid,
  input  logic        cpl_ready,
  output logic [7:0]  cpl_id,
  output logic [31:0] cpl_cycles,
  output logic        busy,
  input  logic        err_clr,
  output logic        err_timeout
);

  localparam logic [31:0] TIMEOUT_L = 32'(TIMEOUT_CYCLES);
  localparam bit          WDOG_EN   = (TIMEOUT_CYCLES != 0);

  state_e      state_q, state_d;
  desc_t       work_q, work_d;
  logic [31:0] cnt_q, cnt_d;
  logic        cpl_valid_q, cpl_valid_d;
  logic [7:0]  cpl_id_q, cpl_id_d;
  logic [31:0] cpl_cycles_q, cpl_cycles_d;
  logic        w_en_q, w_en_d;
  logic [1:0]  wsel_q, wsel_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;

  desc_t       fifo_wr, fifo_head;
  logic        fifo_pop, fifo_full, fifo_empty;
  logic        cpl_pop, wdog_hit;

  assign fifo_wr = '{id: desc_id, mapping: desc_mapping, shape1: desc_shape1,
                     shape2: desc_shape2, op: desc_op};

  desc_fifo #(
    .DEPTH (DESC_DEPTH)
  ) u_desc_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (desc_valid),
    .pop     (fifo_pop),
    .wr_data (fifo_wr),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Sequencing, cycle counter, completion slot and watchdog.
  always_comb begin
    state_d      = state_q;
    work_d       = work_q;
    cnt_d        = cnt_q;
    cpl_valid_d  = cpl_valid_q;
    cpl_id_d     = cpl_id_q;
    cpl_cycles_d = cpl_cycles_q;
    err_d        = err_q;
    fifo_pop     = 1'b0;

    cpl_pop = cpl_valid_q && cpl_ready;
    if (cpl_pop) cpl_valid_d = 1'b0;

    unique case (state_q)
      // Holding off while done is still high keeps shape/mapping writes from being dropped.
      ST_IDLE: begin
        if (!fifo_empty && !dla_done) begin
          fifo_pop = 1'b1;
          work_d   = fifo_head;
          state_d  = ST_WR_MAP;
        end
      end
      ST_WR_MAP:   state_d = ST_WR_SH1;
      ST_WR_SH1:   state_d = ST_WR_SH2;
      ST_WR_SH2:   state_d = ST_WR_START;
      ST_WR_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!dla_done) begin
          if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
        end else if (!cpl_valid_q || cpl_pop) begin
          cpl_valid_d  = 1'b1;
          cpl_id_d     = work_q.id;
          cpl_cycles_d = cnt_q;
          state_d      = ST_WR_CLEAR;
        end
      end
      ST_WR_CLEAR: state_d = ST_WAIT_IDLE;
      ST_WAIT_IDLE: begin
        if (!dla_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Fires once, on the increment that brings the counter to the threshold.
    wdog_hit = WDOG_EN && (state_q == ST_WAIT_DONE) && !dla_done &&
               (cnt_q != '1) && (cnt_q == TIMEOUT_L - 32'd1);
    if (err_clr)  err_d = 1'b0;
    if (wdog_hit) err_d = 1'b1;
  end

  // Write-port outputs are registered, so they are decoded from the next state.
  always_comb begin
    w_en_d  = 1'b0;
    wsel_d  = WSEL_MAPPING;
    wdata_d = '0;
    unique case (state_d)
      ST_WR_MAP: begin
        w_en_d  = 1'b1;
        wsel_d  = WSEL_MAPPING;
        wdata_d = work_d.mapping;
      end
      ST_WR_SH1: begin
        w_en_d  = 1'b1;
        wsel_d  = WSEL_SHAPE1;
        wdata_d = work_d.shape1;
      end
      ST_WR_SH2: begin
        w_en_d  = 1'b1;
        wsel_d  = WSEL_SHAPE2;
        wdata_d = work_d.shape2;
      end
      ST_WR_START: begin
        w_en_d  = 1'b1;
        wsel_d  = WSEL_OPCFG;
        wdata_d = op_with_start(work_d.op, 1'b1);
      end
      ST_WR_CLEAR: begin
        w_en_d  = 1'b1;
        wsel_d  = WSEL_OPCFG;
        wdata_d = op_with_start(work_d.op, 1'b0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      work_q       <= '0;
      cnt_q        <= '0;
      cpl_valid_q  <= 1'b0;
      cpl_id_q     <= '0;
      cpl_cycles_q <= '0;
      w_en_q       <= 1'b0;
      wsel_q       <= WSEL_MAPPING;
      wdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      work_q       <= work_d;
      cnt_q        <= cnt_d;
      cpl_valid_q  <= cpl_valid_d;
      cpl_id_q     <= cpl_id_d;
      cpl_cycles_q <= cpl_cycles_d;
      w_en_q       <= w_en_d;
      wsel_q       <= wsel_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
    end
  end

  assign desc_ready     = !fifo_full;
  assign busy           = (state_q != ST_IDLE) || !fifo_empty;
  assign ctrl_reg_w_en  = w_en_q;
  assign ctrl_reg_wsel  = wsel_q;
  assign ctrl_reg_wdata = wdata_q;
  assign cpl_valid      = cpl_valid_q;
  assign cpl_id         = cpl_id_q;
  assign cpl_cycles     = cpl_cycles_q;
  assign err_timeout    = err_q;

endmodule

// File: tb/tb_dla_layer_launcher.sv
// Directed bench for dla_layer_launcher with a behavioural accelerator model
// and scoreboards for control-register writes and completions.
module tb_dla_layer_launcher;
  import dla_launcher_pkg::*;

  typedef struct packed { logic [1:0] wsel; logic [31:0] wdata; } wr_t;
  typedef struct packed { logic [7:0] id; logic [31:0] cycles; } cpl_exp_t;
  typedef struct packed { int delay; int linger; } job_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        desc_valid, desc_ready;
  logic [7:0]  desc_id;
  logic [31:0] desc_mapping, desc_shape1, desc_shape2, desc_op;
  logic        ctrl_reg_w_en;
  logic [1:0]  ctrl_reg_wsel;
  logic [31:0] ctrl_reg_wdata;
  logic        dla_done;
  logic        cpl_valid, cpl_ready;
  logic [7:0]  cpl_id;
  logic [31:0] cpl_cycles;
  logic        busy, err_clr, err_timeout;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_starts = 0;
  int n_clears = 0;
  int start_cyc = 0;

  wr_t      exp_wr [$];
  cpl_exp_t exp_cpl[$];
  job_t     acc_q  [$];
  int       map_cycs[$];
  int       clr_cycs[$];

  dla_layer_launcher #(
    .DESC_DEPTH     (4),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .desc_valid     (desc_valid),
    .desc_ready     (desc_ready),
    .desc_id        (desc_id),
    .desc_mapping   (desc_mapping),
    .desc_shape1    (desc_shape1),
    .desc_shape2    (desc_shape2),
    .desc_op        (desc_op),
    .ctrl_reg_w_en  (ctrl_reg_w_en),
    .ctrl_reg_wsel  (ctrl_reg_wsel),
    .ctrl_reg_wdata (ctrl_reg_wdata),
    .dla_done       (dla_done),
    .cpl_valid      (cpl_valid),
    .cpl_ready      (cpl_ready),
    .cpl_id         (cpl_id),
    .cpl_cycles     (cpl_cycles),
    .busy           (busy),
    .err_clr        (err_clr),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard plus bookkeeping of start/clear/map cycles.
  always @(negedge clk) begin
    wr_t e;
    if (ctrl_reg_w_en) begin
      if (exp_wr.size() == 0) begin
        check(32'(ctrl_reg_w_en), 32'd0, "unexpected_write");
      end else begin
        e = exp_wr.pop_front();
        check(32'(ctrl_reg_wsel), 32'(e.wsel), "wr_wsel");
        check(ctrl_reg_wdata, e.wdata, "wr_wdata");
      end
      if (ctrl_reg_wsel != WSEL_OPCFG) check(32'(dla_done), 32'd0, "write_while_done");
      if (ctrl_reg_wsel == WSEL_MAPPING) map_cycs.push_back(cyc);
      if (ctrl_reg_wsel == WSEL_OPCFG && ctrl_reg_wdata[0]) begin
        n_starts++;
        start_cyc = cyc;
      end
      if (ctrl_reg_wsel == WSEL_OPCFG && !ctrl_reg_wdata[0]) begin
        n_clears++;
        clr_cycs.push_back(cyc);
      end
    end
  end

  // Completion scoreboard: a handshake seen here is consumed at the next edge.
  always @(negedge clk) begin
    cpl_exp_t c;
    if (rst && cpl_valid && cpl_ready) begin
      if (exp_cpl.size() == 0) begin
        check(32'(cpl_valid), 32'd0, "unexpected_cpl");
      end else begin
        c = exp_cpl.pop_front();
        check(32'(cpl_id), 32'(c.id), "cpl_id");
        check(cpl_cycles, c.cycles, "cpl_cycles");
      end
    end
  end

  // Accelerator model: done rises after 'delay' idle WAIT_DONE cycles and
  // falls 'linger' cycles after the start bit is released.
  initial begin : acc_model
    job_t job;
    bit   clr_seen;
    dla_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && ctrl_reg_w_en && ctrl_reg_wsel == WSEL_OPCFG && ctrl_reg_wdata[0]) begin
        if (acc_q.size() == 0) begin
          check(32'(ctrl_reg_w_en), 32'd0, "start_without_layer");
        end else begin
          job = acc_q.pop_front();
          if (job.delay >= 0) begin
            repeat (job.delay + 1) @(posedge clk);
            #1 dla_done = 1'b1;
            clr_seen = 1'b0;
            for (int i = 0; i < 2000 && !clr_seen; i++) begin
              @(negedge clk);
              clr_seen = ctrl_reg_w_en && ctrl_reg_wsel == WSEL_OPCFG && !ctrl_reg_wdata[0];
            end
            repeat (job.linger + 1) @(posedge clk);
            #1 dla_done = 1'b0;
          end
        end
      end
    end
  end

  task automatic push_desc(input logic [7:0] id, input logic [31:0] mapping,
                           input logic [31:0] sh1, input logic [31:0] sh2,
                           input logic [31:0] op, input int delay, input int linger,
                           input bit accept);
    desc_valid   = 1'b1;
    desc_id      = id;
    desc_mapping = mapping;
    desc_shape1  = sh1;
    desc_shape2  = sh2;
    desc_op      = op;
    @(negedge clk);
    check(32'(desc_ready), 32'(accept), "desc_ready");
    @(posedge clk);
    #1 desc_valid = 1'b0;
    if (accept) begin
      exp_wr.push_back('{WSEL_MAPPING, mapping});
      exp_wr.push_back('{WSEL_SHAPE1, sh1});
      exp_wr.push_back('{WSEL_SHAPE2, sh2});
      exp_wr.push_back('{WSEL_OPCFG, {op[31:1], 1'b1}});
      if (delay >= 0) begin
        exp_wr.push_back('{WSEL_OPCFG, {op[31:1], 1'b0}});
        exp_cpl.push_back('{id, 32'(delay)});
      end
      acc_q.push_back('{delay, linger});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cycle(input int c);
    for (int i = 0; i < 5000 && cyc < c; i++) step();
  endtask

  task automatic drain(input int max_cycles, input string tag);
    for (int i = 0; i < max_cycles && exp_cpl.size() != 0; i++) step();
    check(32'(exp_cpl.size()), 32'd0, tag);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && (busy || dla_done); i++) step();
    check(32'(busy), 32'd0, tag);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check(32'(desc_ready),    32'd1, {pfx, "_desc_ready"});
    check(32'(ctrl_reg_w_en), 32'd0, {pfx, "_w_en"});
    check(32'(ctrl_reg_wsel), 32'd0, {pfx, "_wsel"});
    check(ctrl_reg_wdata,     32'd0, {pfx, "_wdata"});
    check(32'(cpl_valid),     32'd0, {pfx, "_cpl_valid"});
    check(32'(cpl_id),        32'd0, {pfx, "_cpl_id"});
    check(cpl_cycles,         32'd0, {pfx, "_cpl_cycles"});
    check(32'(busy),          32'd0, {pfx, "_busy"});
    check(32'(err_timeout),   32'd0, {pfx, "_err_timeout"});
  endtask

  initial begin : global_timeout
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    int base_clears;
    rst          = 1'b0;
    desc_valid   = 1'b0;
    desc_id      = '0;
    desc_mapping = '0;
    desc_shape1  = '0;
    desc_shape2  = '0;
    desc_op      = '0;
    cpl_ready    = 1'b1;
    err_clr      = 1'b0;

    // Reset state.
    #12;
    check_reset_outputs("rst");
    step();
    rst = 1'b1;
    step();

    // Single layer: 100 idle WAIT_DONE cycles, which also trips the 50-cycle watchdog.
    push_desc(8'h05, 32'h0001_2A49, 32'h0010_0020, 32'h0003_0004, 32'h0000_0401, 100, 0, 1'b1);
    drain(400, "single_drain");
    wait_idle("single_idle");
    check(32'(err_timeout), 32'd1, "single_err_set");
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    check(32'(err_timeout), 32'd0, "single_err_clr");
    step();

    // FIFO full: five accepted, the sixth rejected and never completed.
    push_desc(8'h11, 32'h1111_0000, 32'h1111_0001, 32'h1111_0002, 32'h1111_0010, 20, 0, 1'b1);
    push_desc(8'h12, 32'h1212_0000, 32'h1212_0001, 32'h1212_0002, 32'h1212_0013, 3, 0, 1'b1);
    push_desc(8'h13, 32'h1313_0000, 32'h1313_0001, 32'h1313_0002, 32'h1313_0020, 4, 0, 1'b1);
    push_desc(8'h14, 32'h1414_0000, 32'h1414_0001, 32'h1414_0002, 32'h1414_0031, 5, 0, 1'b1);
    push_desc(8'h15, 32'h1515_0000, 32'h1515_0001, 32'h1515_0002, 32'h1515_0040, 6, 0, 1'b1);
    push_desc(8'hEE, 32'hEEEE_0000, 32'hEEEE_0001, 32'hEEEE_0002, 32'hEEEE_0001, 2, 0, 1'b0);
    drain(600, "full_drain");
    wait_idle("full_idle");

    // Lingering done: next mapping write waits for done to fall.
    map_cycs.delete();
    clr_cycs.delete();
    push_desc(8'h21, 32'h2121_0000, 32'h2121_0001, 32'h2121_0002, 32'h2121_0100, 4, 3, 1'b1);
    push_desc(8'h22, 32'h2222_0000, 32'h2222_0001, 32'h2222_0002, 32'h2222_0201, 4, 0, 1'b1);
    drain(300, "linger_drain");
    wait_idle("linger_idle");
    check(32'(map_cycs.size()), 32'd2, "linger_map_count");
    if (map_cycs.size() == 2 && clr_cycs.size() >= 1)
      check(32'(map_cycs[1] - clr_cycs[0]), 32'd6, "linger_gap");

    // Completion backpressure across two layers.
    map_cycs.delete();
    clr_cycs.delete();
    cpl_ready   = 1'b0;
    base_clears = n_clears;
    push_desc(8'hA1, 32'hA1A1_0000, 32'hA1A1_0001, 32'hA1A1_0002, 32'hA1A1_0300, 8, 0, 1'b1);
    push_desc(8'hB2, 32'hB2B2_0000, 32'hB2B2_0001, 32'hB2B2_0002, 32'hB2B2_0401, 6, 0, 1'b1);
    repeat (80) step();
    check(32'(n_clears - base_clears), 32'd1, "bp_single_clear");
    check(32'(cpl_valid), 32'd1, "bp_cpl_valid");
    check(32'(cpl_id), 32'hA1, "bp_cpl_id_held");
    check(32'(busy), 32'd1, "bp_busy");
    if (map_cycs.size() == 2 && clr_cycs.size() >= 1)
      check(32'(map_cycs[1] - clr_cycs[0]), 32'd3, "bp_min_gap");
    else
      check(32'(map_cycs.size()), 32'd2, "bp_map_count");
    cpl_ready = 1'b1;
    drain(200, "bp_drain");
    wait_idle("bp_idle");

    // Watchdog: done never arrives.
    base_clears = n_starts;
    push_desc(8'h77, 32'h7777_0000, 32'h7777_0001, 32'h7777_0002, 32'h7777_0500, -1, 0, 1'b1);
    for (int i = 0; i < 50 && n_starts == base_clears; i++) step();
    check(32'(n_starts - base_clears), 32'd1, "wd_started");
    goto_cycle(start_cyc + 49);
    @(negedge clk);
    check(32'(err_timeout), 32'd0, "wd_before_threshold");
    goto_cycle(start_cyc + 51);
    @(negedge clk);
    check(32'(err_timeout), 32'd1, "wd_set");
    goto_cycle(start_cyc + 70);
    @(negedge clk);
    check(32'(err_timeout), 32'd1, "wd_sticky");
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    repeat (5) step();
    @(negedge clk);
    check(32'(err_timeout), 32'd0, "wd_cleared");
    check(32'(busy), 32'd1, "wd_still_waiting");

    // Reset while stalled in WAIT_DONE: outputs return asynchronously.
    step();
    rst = 1'b0;
    #2;
    check_reset_outputs("midrst");
    step();
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check(32'(busy), 32'd0, "post_rst_busy");
    check(32'(ctrl_reg_w_en), 32'd0, "post_rst_w_en");

    check(32'(exp_wr.size()), 32'd0, "wr_queue_empty");
    check(32'(exp_cpl.size()), 32'd0, "cpl_queue_empty");
    check(32'(acc_q.size()), 32'd0, "acc_queue_empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
